// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: PCM frame handshake between a producer and the I2S transmitter.
interface audio_i2s_tx_if #(
    parameter int SAMPLE_WIDTH = 16
) ();
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;
    logic                    sample_valid;
    logic                    sample_ready;
    modport master (output sample_left, sample_right, sample_valid, input sample_ready);
    modport slave (input sample_left, sample_right, sample_valid, output sample_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter with a one-deep frame holding register and saturating underflow counter.
// Build option AUDIO_I2S_TX_UNDERFLOW_MUTE_EN: underflow frames transmit silence instead of repeating.
module audio_i2s_tx #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    audio_i2s_tx_if.slave        s_if,
    output logic                 audio_sclk,
    output logic                 audio_lrck,
    output logic                 audio_dac,
    output logic [15:0]          underflow_count
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
    localparam logic [BW-1:0] SW       = BW'(SAMPLE_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] TOP = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);
`ifdef AUDIO_I2S_TX_UNDERFLOW_MUTE_EN
    localparam logic MUTE = 1'b1;
`else
    localparam logic MUTE = 1'b0;
`endif

    logic [DW-1:0]           div_q, div_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic                    sclk_q, sclk_d, lrck_q, lrck_d, dac_q, dac_d;
    logic                    full_q, full_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [SAMPLE_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [15:0]             uf_q, uf_d;
    logic                    boundary, accept, right;
    logic [BW-1:0]           p;
    logic [SAMPLE_WIDTH-1:0] word;

    always_comb begin
        boundary = div_q == '0 && bit_q == '0;
        accept   = s_if.sample_valid && !full_q;
        right    = bit_q >= SLOT;
        p        = right ? bit_q - SLOT : bit_q;
        word     = right ? act_r_q : act_l_q;
        div_d    = div_q == DIV_LAST ? '0 : div_q + 1'b1;
        bit_d    = div_q != DIV_LAST ? bit_q : bit_q == BIT_LAST ? '0 : bit_q + 1'b1;
        sclk_d   = div_q >= DIV_HALF;
        lrck_d   = right;
        // slot position p carries sample bit [SAMPLE_WIDTH-p]: one-sclk MSB delay after lrck
        dac_d    = p != '0 && p <= SW && |(word & (TOP >> (p - 1'b1)));
        hold_l_d = accept ? s_if.sample_left : hold_l_q;
        hold_r_d = accept ? s_if.sample_right : hold_r_q;
        full_d   = accept || (full_q && !boundary);
        act_l_d  = boundary && full_q ? hold_l_q : boundary && MUTE ? '0 : act_l_q;
        act_r_d  = boundary && full_q ? hold_r_q : boundary && MUTE ? '0 : act_r_q;
        uf_d     = boundary && !full_q && uf_q != 16'hFFFF ? uf_q + 16'd1 : uf_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            dac_q    <= 1'b0;
            full_q   <= 1'b0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            act_l_q  <= '0;
            act_r_q  <= '0;
            uf_q     <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            lrck_q   <= lrck_d;
            dac_q    <= dac_d;
            full_q   <= full_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            act_l_q  <= act_l_d;
            act_r_q  <= act_r_d;
            uf_q     <= uf_d;
        end
    end

    assign s_if.sample_ready = !full_q;
    assign audio_sclk        = sclk_q;
    assign audio_lrck        = lrck_q;
    assign audio_dac         = dac_q;
    assign underflow_count   = uf_q;
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Standalone I2S transmitter in the audio clock domain (clk_12_288_mhz).
- Replaces the inline shifter/counter in the core top level.
- Accepts stereo PCM frames through a valid/ready handshake into a one-deep holding register.
- Generates bit clock, word select and serial data for the Pocket audio DAC, and counts frame underflows.

Parameters:
- CLK_DIV, 4: clk cycles per bit-clock period; even, >=2. 12.288 MHz / 4 = 3.072 MHz sclk.
- SAMPLE_WIDTH, 16: signed PCM bits per channel.
- SLOT_BITS, 32: sclk periods per channel slot. Requires SAMPLE_WIDTH <= SLOT_BITS-1; default gives fs = 48 kHz.

Ports:
- clk  in  1  audio clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sample_left  in  SAMPLE_WIDTH  left PCM, two's complement.
- sample_right  in  SAMPLE_WIDTH  right PCM, two's complement.
- sample_valid  in  1  producer has a frame on sample_left/right.
- sample_ready  out  1  holding register empty; frame accepted when valid && ready.
- audio_sclk  out  1  I2S bit clock.
- audio_lrck  out  1  word select; 0 = left slot, 1 = right slot.
- audio_dac  out  1  serial data, MSB first.
- underflow_count  out  16  frames started with no new sample; saturating.

Behaviour:
- Counters:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - bit_cnt runs 0..2*SLOT_BITS-1 and advances by 1, wrapping to 0, on the cycle where div_cnt == CLK_DIV-1.
- Outputs are registered and update in the cycle after the counter state that produces them:
  - audio_sclk = 0 when div_cnt < CLK_DIV/2, else 1.
  - audio_lrck = (bit_cnt >= SLOT_BITS).
  - audio_dac: within a slot at position p = bit_cnt mod SLOT_BITS, carries sample bit [SAMPLE_WIDTH-p] for 1 <= p <= SAMPLE_WIDTH, else 0.
  - MSB therefore lags the lrck edge by exactly one sclk period (I2S standard). audio_dac and audio_lrck change only on sclk falling edges.
- Frame boundary is the cycle with bit_cnt == 0 and div_cnt == 0:
  - If holding is full: copy holding into the active L/R registers and mark holding empty.
  - If holding is empty (underflow): underflow_count increments, saturating at 16'hFFFF. The active registers keep the previous frame (see optional feature).
- Handshake:
  - sample_ready = !holding_full, registered-state driven, no combinational path from sample_valid.
  - Accept (valid && ready) loads holding and sets it full on the next edge.
  - The frame-boundary drain takes effect at the same edge; ready rises one cycle later. No simultaneous drain+accept in a single cycle.
  - sample_left/right are sampled only on accept. Values presented while ready = 0 are ignored; the producer holds them.
- Reset (reset_n low at a rising edge), regardless of state:
  - div_cnt = 0, bit_cnt = 0.
  - audio_sclk = 0, audio_lrck = 0, audio_dac = 0.
  - holding empty, so sample_ready = 1 in the first cycle after release.
  - Active L/R = 0, underflow_count = 0.
- Reset mid-frame abandons the current bits. The first frame boundary after release is the first cycle with reset_n high.
- Sample transmitted is unmodified two's complement; no sign extension into padding bits.

Optional Feature:
- Macro: AUDIO_I2S_TX_UNDERFLOW_MUTE_EN.
- Defined: on an underflow frame the active L/R registers load 0, so silence is output until the next accepted frame.
- Undefined: the previous frame is retransmitted on underflow.
- underflow_count behaves identically in both builds.

Test Plan:
- Reset release, no samples: audio_sclk period is 4 clk with 50% duty; audio_lrck toggles every 128 clk; audio_dac stays 0; underflow_count reads 1 after the first boundary and 2 after 256 clk.
- Accept L=16'hA5C3, R=16'h0001 before the first boundary:
  - Left slot: dac bits at p=1..16 are 1010_0101_1100_0011, p=0 and 17..31 are 0.
  - Right slot: only p=16 is 1.
  - sample_ready is 0 for the cycles between accept and the boundary.
- Continuous producer, one frame per 256 clk with incrementing values: every frame is transmitted in order and underflow_count stays 0.
- Second frame offered while holding is full: sample_ready stays 0 until one cycle after the next boundary. The first frame is transmitted and the held frame is not overwritten.
- Underflow after frame L=16'h7FFF: the next frame repeats 7FFF (macro undefined) or is all-zero (macro defined); underflow_count increments by 1.
- Assert reset_n low at bit_cnt = 40: all outputs are 0 the next cycle, sample_ready = 1, underflow_count = 0. After release the first audio_lrck rise occurs 128 clk later.
